// File: rtl/mem_access_controller.sv
// mem_access_controller
// Sequences one CPU load/store into a single word-aligned memory transaction.
// Byte lanes are chosen from the access size and the low address bits.
// The pipeline is stalled through busywait_o until memory acknowledges the
// transaction or the timeout expires.
// Sub-word load data is sign- or zero-extended before it reaches the CPU.
// Illegal or misaligned requests are rejected with a one-cycle error pulse
// and never reach memory.
module mem_access_controller #(
  parameter int unsigned TIMEOUT = 255   // ACCESS cycles without ack before abort, 1..65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] address_i,
  input  logic [31:0] writedata_i,
  output logic        busywait_o,
  output logic [31:0] readdata_o,
  output logic        error_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_writedata_o,
  output logic [3:0]  mem_byteen_o,
  input  logic [31:0] mem_readdata_i,
  input  logic        mem_ack_i
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_writedata_q;
  logic [3:0]  mem_byteen_q;
  logic [1:0]  offset_q;
  logic [2:0]  func3_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [15:0] count_q;
  logic [31:0] readdata_q;
  logic        error_q;

  logic        req_any;
  logic        req_legal;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] lane_word;
  logic [31:0] load_data_d;

  // Decode the CPU request: legality, byte lanes and lane-replicated store data.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    req_any    = read_i | write_i;
    req_legal  = 1'b0;
    req_byteen = 4'b1111;
    req_wdata  = writedata_i;

    unique case (func3_i)
      3'b000, 3'b001, 3'b010: req_legal = read_i ^ write_i;
      3'b100, 3'b101:         req_legal = read_i & ~write_i;  // unsigned forms are loads only
      default:                req_legal = 1'b0;
    endcase

    unique case (func3_i[1:0])
      2'b00: begin
        req_byteen = 4'b0001 << address_i[1:0];
        req_wdata  = {4{writedata_i[7:0]}};
      end
      2'b01: begin
        if (address_i[0]) req_legal = 1'b0;
        req_byteen = 4'b0011 << address_i[1:0];
        req_wdata  = {2{writedata_i[15:0]}};
      end
      2'b10: begin
        if (address_i[1:0] != 2'b00) req_legal = 1'b0;
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Bring the addressed lane down to bit 0 and extend it according to the access type.
  always_comb begin
    lane_word   = mem_readdata_i >> {offset_q, 3'b000};
    load_data_d = lane_word;
    unique case (func3_q)
      3'b000:  load_data_d = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data_d = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data_d = {24'h0, lane_word[7:0]};
      3'b101:  load_data_d = {16'h0, lane_word[15:0]};
      default: load_data_d = lane_word;
    endcase
  end

  // Stall follows the request decode while idle, and the registered state otherwise.
  // Holding reset also forces it low, so a CPU that keeps READ/WRITE asserted
  // through reset does not see a stall.
  always_comb begin
    unique case (state_q)
      IDLE:    busywait_o = rst_n & req_legal;
      ACCESS:  busywait_o = 1'b1;
      default: busywait_o = 1'b0;
    endcase
  end

  // Transaction FSM. All memory-side outputs, the error pulse and the load result are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_byteen_q    <= '0;
      offset_q        <= '0;
      func3_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      count_q         <= '0;
      readdata_q      <= '0;
      error_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_legal) begin
            state_q         <= ACCESS;
            mem_address_q   <= {address_i[31:2], 2'b00};
            mem_writedata_q <= req_wdata;
            mem_byteen_q    <= req_byteen;
            offset_q        <= address_i[1:0];
            func3_q         <= func3_i;
            mem_read_q      <= read_i;
            mem_write_q     <= write_i;
            count_q         <= '0;
          end else if (req_any) begin
            error_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            // An ack on the timeout edge still counts as a good completion.
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) readdata_q <= load_data_d;
          end else if (count_q == TimeoutLast) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            error_q     <= 1'b1;
          end else begin
            count_q <= count_q + 16'd1;
          end
        end
        DONE: begin
          // A request still visible here belongs to the instruction just finished.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_address_o   = mem_address_q;
  assign mem_writedata_o = mem_writedata_q;
  assign mem_byteen_o    = mem_byteen_q;
  assign readdata_o      = readdata_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: directed cases from the block's behaviour
// description, followed by randomized loads/stores checked against an
// arithmetic reference model of sizes, lanes, extension and timeout.
module tb_mem_access_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_i, write_i;
  logic [2:0]  func3_i;
  logic [31:0] address_i, writedata_i;
  logic        busywait_o;
  logic [31:0] readdata_o;
  logic        error_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_address_o, mem_writedata_o;
  logic [3:0]  mem_byteen_o;
  logic [31:0] mem_readdata_i;
  logic        mem_ack_i;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_rd = '0;

  mem_access_controller #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_i         (read_i),
    .write_i        (write_i),
    .func3_i        (func3_i),
    .address_i      (address_i),
    .writedata_i    (writedata_i),
    .busywait_o     (busywait_o),
    .readdata_o     (readdata_o),
    .error_o        (error_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .mem_address_o  (mem_address_o),
    .mem_writedata_o(mem_writedata_o),
    .mem_byteen_o   (mem_byteen_o),
    .mem_readdata_i (mem_readdata_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] addr);
    if (rd == wr) return 1'b0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (f3[2] && wr) return 1'b0;
    return (addr % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_byteen(input logic [2:0] f3, input logic [31:0] addr);
    int mask;
    mask = (1 << size_of(f3)) - 1;
    return 32'(mask << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] mword);
    longint unsigned v, span;
    int sz;
    sz   = size_of(f3);
    span = 64'd1 << (8 * sz);
    v    = (longint'(mword) >> (8 * (addr % 4))) % span;
    if (!f3[2] && sz < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  // One CPU instruction, starting and ending at posedge+1 of an IDLE cycle.
  // ack_delay < 0 means memory never acknowledges.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mword,
                         input int ack_delay);
    logic legal, timed_out;
    int   n_acc;
    legal = model_legal(rd, wr, f3, addr);
    check({name, "/err_before"}, error_o, 1'b0);
    read_i = rd; write_i = wr; func3_i = f3; address_i = addr;
    writedata_i = wd; mem_readdata_i = mword; mem_ack_i = 1'b0;
    #1;
    check({name, "/busy_idle"}, busywait_o, legal);
    check({name, "/strobe_idle"}, {mem_read_o, mem_write_o}, 2'b00);
    @(posedge clk); #1;
    if (!legal) begin
      check({name, "/err_pulse"}, error_o, 1'b1);
      check({name, "/strobe_illegal"}, {mem_read_o, mem_write_o}, 2'b00);
      check({name, "/busy_illegal"}, busywait_o, 1'b0);
      read_i = 1'b0; write_i = 1'b0;
      @(posedge clk); #1;
      check({name, "/err_clear"}, error_o, 1'b0);
      check({name, "/strobe_after"}, {mem_read_o, mem_write_o}, 2'b00);
      check({name, "/rd_hold"}, readdata_o, exp_rd);
      return;
    end
    if (ack_delay >= 0 && ack_delay < TO) begin
      n_acc = ack_delay + 1; timed_out = 1'b0;
    end else begin
      n_acc = TO; timed_out = 1'b1;
    end
    for (int k = 0; k < n_acc; k++) begin
      check({name, "/strobe_acc"}, {mem_read_o, mem_write_o}, {rd, wr});
      check({name, "/busy_acc"}, busywait_o, 1'b1);
      check({name, "/addr"}, mem_address_o, addr & 32'hFFFF_FFFC);
      check({name, "/byteen"}, mem_byteen_o, model_byteen(f3, addr));
      if (wr) check({name, "/wdata"}, mem_writedata_o, model_wdata(f3, wd));
      check({name, "/rd_acc"}, readdata_o, exp_rd);
      check({name, "/err_acc"}, error_o, 1'b0);
      mem_ack_i = (k == ack_delay);
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
    end
    if (rd && !timed_out) exp_rd = model_load(f3, addr, mword);
    check({name, "/strobe_done"}, {mem_read_o, mem_write_o}, 2'b00);
    check({name, "/busy_done"}, busywait_o, 1'b0);
    check({name, "/err_done"}, error_o, timed_out);
    check({name, "/rd_done"}, readdata_o, exp_rd);
    read_i = 1'b0; write_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    read_i = 1'b0; write_i = 1'b0; func3_i = '0; address_i = '0;
    writedata_i = '0; mem_readdata_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", busywait_o, 1'b0);
    check("reset/readdata", readdata_o, 32'h0);
    check("reset/error", error_o, 1'b0);
    check("reset/strobes", {mem_read_o, mem_write_o}, 2'b00);
    check("reset/addr", mem_address_o, 32'h0);
    check("reset/byteen", mem_byteen_o, 4'h0);
    check("reset/wdata", mem_writedata_o, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed loads from the same memory word
    run_txn("LB",  1, 0, 3'b000, 32'h0000_1407, 32'h0, 32'h80FF_1234, 0);
    check("LB/value", exp_rd, 32'hFFFF_FF80);
    run_txn("LHU", 1, 0, 3'b101, 32'h0000_1402, 32'h0, 32'h80FF_1234, 0);
    check("LHU/value", readdata_o, 32'h0000_80FF);
    run_txn("LH",  1, 0, 3'b001, 32'h0000_1402, 32'h0, 32'h80FF_1234, 0);
    check("LH/value", readdata_o, 32'hFFFF_80FF);

    // Store with delayed ack; READDATA must keep the last load value
    run_txn("SH", 0, 1, 3'b001, 32'h0000_4006, 32'hABCD_1234, 32'hDEAD_BEEF, 3);
    check("SH/rd_kept", readdata_o, 32'hFFFF_80FF);

    // Illegal requests
    run_txn("LW_mis", 1, 0, 3'b010, 32'h0000_1402, 32'h0, 32'h1111_1111, 0);
    run_txn("RW_both", 1, 1, 3'b010, 32'h0000_1000, 32'h5, 32'h1111_1111, 0);
    run_txn("S_f3_100", 0, 1, 3'b100, 32'h0000_1000, 32'h5, 32'h1111_1111, 0);

    // Timeout, then ack on the last permitted cycle
    run_txn("LW_to", 1, 0, 3'b010, 32'h0000_2000, 32'h0, 32'h1357_9BDF, -1);
    run_txn("LW_ack_last", 1, 0, 3'b010, 32'h0000_2000, 32'h0, 32'h2468_ACE0, TO - 1);
    check("LW_ack_last/value", readdata_o, 32'h2468_ACE0);

    // Reset in the middle of ACCESS, with READ still held
    read_i = 1'b1; write_i = 1'b0; func3_i = 3'b010; address_i = 32'h0000_3000;
    mem_readdata_i = 32'hCAFE_F00D; mem_ack_i = 1'b0;
    @(posedge clk); #1;
    check("rstmid/in_access", mem_read_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid/mem_read", mem_read_o, 1'b0);
    check("rstmid/busy", busywait_o, 1'b0);
    check("rstmid/readdata", readdata_o, 32'h0);
    check("rstmid/error", error_o, 1'b0);
    exp_rd = '0;
    @(posedge clk); #1;
    read_i = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid/no_err_after", error_o, 1'b0);
    run_txn("LW_post", 1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1);
    check("LW_post/value", readdata_o, 32'hCAFE_F00D);

    // Randomized mix of loads, stores, illegal forms and ack delays
    for (int i = 0; i < 60; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          dir, pick;
      dir = int'($urandom_range(0, 4));
      rd  = (dir != 1);
      wr  = (dir == 1) || (dir == 4);
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      run_txn("rand", rd, wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
